// File: rtl/i2c_target_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_regfile
// Purpose  : Oversampling I2C target with an 8-bit register file, pointer
//            write, burst write and auto-increment burst read. Define
//            I2C_TGT_GLITCH_FILTER_EN to add a 3-sample majority filter.
// Revision : 1.0  initial release
// ============================================================================
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR  = 7'h1D,
    parameter int         REG_DEPTH = 32,
    parameter int         PTR_W     = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i2c_scl,
    inout  wire              i2c_sda,
    input  logic             i_host_we,
    input  logic [PTR_W-1:0] i_host_addr,
    input  logic [7:0]       i_host_wdata,
    output logic             o_wr_strobe,
    output logic [PTR_W-1:0] o_wr_addr,
    output logic [7:0]       o_wr_data,
    output logic             o_busy,
    output logic             o_collision,
    output logic             o_sda_oe
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    logic [1:0]       r_scl_sync, r_sda_sync;
    logic             r_scl_hist, r_sda_hist;
    logic             w_scl, w_sda;
    state_t           r_state;
    logic [2:0]       r_bitcnt;
    logic [6:0]       r_shift;
    logic             r_rw, r_phase, r_sda_oe, r_busy, r_collision;
    logic             r_wr_strobe;
    logic [PTR_W-1:0] r_ptr, r_wr_addr;
    logic [7:0]       r_wr_data;
    logic [7:0]       r_mem [REG_DEPTH];

    // Idle bus level is high, so the conditioning flops reset to 1 to avoid
    // phantom edges after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i2c_scl};
            r_sda_sync <= {r_sda_sync[0], i2c_sda};
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [2:0] r_scl_maj, r_sda_maj;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_maj <= 3'b111;
            r_sda_maj <= 3'b111;
        end else begin
            r_scl_maj <= {r_scl_maj[1:0], r_scl_sync[1]};
            r_sda_maj <= {r_sda_maj[1:0], r_sda_sync[1]};
        end
    end
    assign w_scl = (r_scl_maj[0] & r_scl_maj[1]) | (r_scl_maj[0] & r_scl_maj[2]) | (r_scl_maj[1] & r_scl_maj[2]);
    assign w_sda = (r_sda_maj[0] & r_sda_maj[1]) | (r_sda_maj[0] & r_sda_maj[2]) | (r_sda_maj[1] & r_sda_maj[2]);
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_hist <= w_scl;
            r_sda_hist <= w_sda;
        end
    end

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_last, w_bus_we, w_host_drop;
    logic [7:0] w_byte, w_rd_byte;

    assign w_scl_rise  = w_scl & ~r_scl_hist;
    assign w_scl_fall  = ~w_scl & r_scl_hist;
    // SCL must be high on both sides of the SDA edge to qualify as START/STOP.
    assign w_start     = ~w_sda & r_sda_hist & w_scl & r_scl_hist;
    assign w_stop      = w_sda & ~r_sda_hist & w_scl & r_scl_hist;
    assign w_byte      = {r_shift, w_sda};
    assign w_last      = (r_bitcnt == 3'd0);
    assign w_rd_byte   = r_mem[r_ptr];
    assign w_bus_we    = (r_state == S_WR_DATA) && w_scl_rise && w_last && !w_start && !w_stop;
    assign w_host_drop = i_host_we && w_bus_we && (i_host_addr == r_ptr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_bitcnt    <= 3'd7;
            r_shift     <= 7'd0;
            r_rw        <= 1'b0;
            r_phase     <= 1'b0;
            r_ptr       <= '0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_start) begin
                r_state  <= S_ADDR;
                r_bitcnt <= 3'd7;
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_PTR, S_WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt - 3'd1;
                            if (w_last) begin
                                r_phase <= 1'b0;
                                if (r_state == S_ADDR) begin
                                    if (w_byte[7:1] == DEV_ADDR) begin
                                        r_state <= S_ADDR_ACK;
                                        r_rw    <= w_byte[0];
                                        r_busy  <= 1'b1;
                                    end else begin
                                        r_state <= S_IGNORE;
                                    end
                                end else if (r_state == S_PTR) begin
                                    r_ptr   <= w_byte[PTR_W-1:0];
                                    r_state <= S_PTR_ACK;
                                end else begin
                                    r_wr_strobe <= 1'b1;
                                    r_wr_addr   <= r_ptr;
                                    r_wr_data   <= w_byte;
                                    r_ptr       <= r_ptr + 1'b1;
                                    r_state     <= S_WR_ACK;
                                end
                            end
                        end
                    end
                    // First fall drives ACK low, second fall ends the ACK slot.
                    S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda_oe <= 1'b1;
                                r_phase  <= 1'b1;
                            end else begin
                                r_bitcnt <= 3'd7;
                                if (r_state == S_ADDR_ACK && r_rw) begin
                                    r_shift  <= w_rd_byte[6:0];
                                    r_sda_oe <= ~w_rd_byte[7];
                                    r_ptr    <= r_ptr + 1'b1;
                                    r_state  <= S_RD_DATA;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= (r_state == S_ADDR_ACK) ? S_PTR : S_WR_DATA;
                                end
                            end
                        end
                    end
                    S_RD_DATA: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt - 3'd1;
                            if (w_last) begin
                                r_state <= S_RD_ACK;
                                r_phase <= 1'b0;
                            end
                        end else if (w_scl_fall) begin
                            r_sda_oe <= ~r_shift[6];
                            r_shift  <= {r_shift[5:0], 1'b0};
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) r_state <= S_IGNORE;
                            else       r_phase <= 1'b1;
                        end else if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_bitcnt <= 3'd7;
                                r_shift  <= w_rd_byte[6:0];
                                r_sda_oe <= ~w_rd_byte[7];
                                r_ptr    <= r_ptr + 1'b1;
                                r_state  <= S_RD_DATA;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < REG_DEPTH; i++) r_mem[i] <= 8'h00;
            r_collision <= 1'b0;
        end else begin
            if (i_host_we && !w_host_drop) r_mem[i_host_addr] <= i_host_wdata;
            if (w_bus_we)                  r_mem[r_ptr]       <= w_byte;
            if (w_host_drop)               r_collision        <= 1'b1;
        end
    end

    assign i2c_sda     = r_sda_oe ? 1'b0 : 1'bz;
    assign o_sda_oe    = r_sda_oe;
    assign o_busy      = r_busy;
    assign o_collision = r_collision;
    assign o_wr_strobe = r_wr_strobe;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;

endmodule
`default_nettype wire
